// File: rtl/m1_control_unit_pkg.sv
// Shared codes for the M1 sequencer: opcodes, functs, ALU ops, bus selects, register indices, states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package m1_control_unit_pkg;

    localparam int WORD_SIZE = 16;
    localparam int ALU_OP_W  = 4;
    localparam int SEL_W     = 3;
    localparam int NUM_REGS  = 6;

    // Major opcodes, instruction[15:11]
    localparam logic [4:0] OP_B     = 5'b00010;
    localparam logic [4:0] OP_BEQZ  = 5'b00100;
    localparam logic [4:0] OP_BNEZ  = 5'b00101;
    localparam logic [4:0] OP_ADDIU = 5'b01001;
    localparam logic [4:0] OP_LI    = 5'b01101;
    localparam logic [4:0] OP_LW    = 5'b10011;
    localparam logic [4:0] OP_SW    = 5'b11011;
    localparam logic [4:0] OP_RRR   = 5'b11100;
    localparam logic [4:0] OP_RR    = 5'b11101;

    // Function fields
    localparam logic [4:0] FN_BREAK = 5'b00101;
    localparam logic [1:0] FN_ADDU  = 2'b01;
    localparam logic [1:0] FN_SUBU  = 2'b11;

    // ALU operations
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd2;

    // ALU A-operand sources
    localparam logic [SEL_W-1:0] B1_REGS = 3'd0;
    localparam logic [SEL_W-1:0] B1_SEXT = 3'd1;
    localparam logic [SEL_W-1:0] B1_ZEXT = 3'd2;

    // Write-bus sources
    localparam logic [SEL_W-1:0] B2_PC  = 3'd0;
    localparam logic [SEL_W-1:0] B2_ALU = 3'd1;
    localparam logic [SEL_W-1:0] B2_MEM = 3'd2;
    localparam logic [SEL_W-1:0] B2_RX  = 3'd3;
    localparam logic [SEL_W-1:0] B2_RY  = 3'd4;

    // Register file indices
    localparam logic [2:0] REG_X  = 3'd0;
    localparam logic [2:0] REG_Y  = 3'd1;
    localparam logic [2:0] REG_Z  = 3'd2;
    localparam logic [2:0] REG_SP = 3'd3;
    localparam logic [2:0] REG_T  = 3'd4;
    localparam logic [2:0] REG_IH = 3'd5;

    typedef enum logic [3:0] {
        C_ADDIU, C_LI, C_ADDU, C_SUBU, C_LW, C_SW,
        C_B, C_BEQZ, C_BNEZ, C_BREAK, C_ILLEGAL
    } instr_class_t;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_A, S_FETCH_M, S_DECODE,
        S_EX_A, S_EX_B, S_EX_C, S_EX_Z, S_BR_T,
        S_MEM_R, S_MEM_W, S_HALT
    } state_t;

    // Codes 6 and 7 name no register
    function automatic logic reg_ok(input logic [2:0] r);
        return (r <= REG_IH);
    endfunction

endpackage

// File: rtl/m1_control_unit_decode.sv
// Combinational instruction classifier: class, rx/ry/rz indices, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows the IR contents directly.
module m1_control_unit_decode
    import m1_control_unit_pkg::*;
(
    input  logic [WORD_SIZE-1:0] instruction,
    output instr_class_t         instr_class,
    output logic [2:0]           rx_idx,
    output logic [2:0]           ry_idx,
    output logic [2:0]           rz_idx,
    output logic                 illegal
);

    logic [4:0] opcode;
    logic [4:0] funct;
    logic       regs_ok;

    assign opcode = instruction[15:11];
    assign rx_idx = instruction[10:8];
    assign ry_idx = instruction[7:5];
    assign rz_idx = instruction[4:2];
    assign funct  = instruction[4:0];

    // Classify the opcode and check only the register fields that instruction actually names
    always_comb begin
        instr_class = C_ILLEGAL;
        regs_ok     = 1'b1;
        case (opcode)
            OP_ADDIU: begin instr_class = C_ADDIU; regs_ok = reg_ok(rx_idx); end
            OP_LI:    begin instr_class = C_LI;    regs_ok = reg_ok(rx_idx); end
            OP_BEQZ:  begin instr_class = C_BEQZ;  regs_ok = reg_ok(rx_idx); end
            OP_BNEZ:  begin instr_class = C_BNEZ;  regs_ok = reg_ok(rx_idx); end
            OP_B:     instr_class = C_B;
            OP_LW: begin
                instr_class = C_LW;
                regs_ok     = reg_ok(rx_idx) && reg_ok(ry_idx);
            end
            OP_SW: begin
                instr_class = C_SW;
                regs_ok     = reg_ok(rx_idx) && reg_ok(ry_idx);
            end
            OP_RRR: begin
                if (funct[1:0] == FN_ADDU) begin
                    instr_class = C_ADDU;
                end else if (funct[1:0] == FN_SUBU) begin
                    instr_class = C_SUBU;
                end
                regs_ok = reg_ok(rx_idx) && reg_ok(ry_idx) && reg_ok(rz_idx);
            end
            OP_RR: begin
                if (funct == FN_BREAK) begin
                    instr_class = C_BREAK;
                end
            end
            default: instr_class = C_ILLEGAL;
        endcase
        illegal = (instr_class == C_ILLEGAL) || !regs_ok;
    end

endmodule

// File: rtl/m1_control_unit.sv
// Multicycle M1 sequencer: fetch, decode and one datapath micro-step per clock. Option macro: M1_CTRL_WAIT_EN.
// Latency: 4..7 cycles per instruction at zero wait; strobes are combinational from the current state.
// Backpressure: with M1_CTRL_WAIT_EN, memory states hold (requests stable) until mem_ready; otherwise memory is single-cycle.
module m1_control_unit
    import m1_control_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [WORD_SIZE-1:0] instruction,
    input  logic                 Z_flag,
    input  logic                 mem_ready,
    output logic                 Load_ir,
    output logic                 Load_pc,
    output logic                 Inc_pc,
    output logic                 Load_add_r,
    output logic                 Load_data_r,
    output logic                 Load_Reg_X,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 Load_Reg_SP,
    output logic                 Load_Reg_T,
    output logic                 Load_Reg_IH,
    output logic                 Load_Reg_alu_Y,
    output logic                 Load_alu_Z,
    output logic [SEL_W-1:0]     bus1_sel,
    output logic [SEL_W-1:0]     bus2_sel,
    output logic [SEL_W-1:0]     rf_sel,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 halted,
    output logic                 illegal_op
);

    state_t             state_q, state_d;
    logic               illegal_q, illegal_d;
    logic [NUM_REGS-1:0] load_reg;

    instr_class_t dec_class;
    logic [2:0]   dec_rx, dec_ry, dec_rz;
    logic         dec_illegal;
    logic         mem_done;
    logic         taken;
    logic         is_branch;
    state_t       end_state;

    // The IR is stable from DECODE until the next Load_ir, so decode it live
    m1_control_unit_decode u_decode (
        .instruction (instruction),
        .instr_class (dec_class),
        .rx_idx      (dec_rx),
        .ry_idx      (dec_ry),
        .rz_idx      (dec_rz),
        .illegal     (dec_illegal)
    );

`ifdef M1_CTRL_WAIT_EN
    assign mem_done = mem_ready;
`else
    // Single-cycle memory: every access completes in its first cycle
    assign mem_done = mem_ready | 1'b1;
`endif

    assign taken     = (dec_class == C_BEQZ) ? Z_flag : ~Z_flag;
    assign is_branch = (dec_class inside {C_B, C_BEQZ, C_BNEZ});
    assign end_state = run ? S_FETCH_A : S_IDLE;

    assign Load_Reg_X  = load_reg[REG_X];
    assign Load_Reg_Y  = load_reg[REG_Y];
    assign Load_Reg_Z  = load_reg[REG_Z];
    assign Load_Reg_SP = load_reg[REG_SP];
    assign Load_Reg_T  = load_reg[REG_T];
    assign Load_Reg_IH = load_reg[REG_IH];

    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;

    // State and sticky illegal flag; reset also drops any in-flight memory request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state and per-state datapath strobes
    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;
        Load_ir        = 1'b0;
        Load_pc        = 1'b0;
        Inc_pc         = 1'b0;
        Load_add_r     = 1'b0;
        Load_data_r    = 1'b0;
        load_reg       = '0;
        Load_Reg_alu_Y = 1'b0;
        Load_alu_Z     = 1'b0;
        bus1_sel       = B1_REGS;
        bus2_sel       = B2_PC;
        rf_sel         = REG_X;
        alu_op         = ALU_PASS;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_A;
            end
            S_FETCH_A: begin
                bus2_sel   = B2_PC;
                Load_add_r = 1'b1;
                state_d    = S_FETCH_M;
            end
            S_FETCH_M: begin
                mem_rd = 1'b1;
                if (mem_done) begin
                    bus2_sel = B2_MEM;
                    Load_ir  = 1'b1;
                    Inc_pc   = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    case (dec_class)
                        C_BREAK:        state_d = S_HALT;
                        C_LI:           state_d = S_EX_B;
                        C_BEQZ, C_BNEZ: state_d = S_EX_Z;
                        default:        state_d = S_EX_A;
                    endcase
                end
            end
            S_EX_Z: begin
                // Z_flag reflects rx one cycle later, hence the separate test state
                rf_sel     = dec_rx;
                bus1_sel   = B1_REGS;
                alu_op     = ALU_PASS;
                Load_alu_Z = 1'b1;
                state_d    = S_BR_T;
            end
            S_BR_T: begin
                state_d = taken ? S_EX_A : end_state;
            end
            S_EX_A: begin
                // Branch base is the PC already advanced during fetch
                Load_Reg_alu_Y = 1'b1;
                if (is_branch) begin
                    bus2_sel = B2_PC;
                end else begin
                    rf_sel   = dec_rx;
                    bus2_sel = B2_RX;
                end
                state_d = S_EX_B;
            end
            S_EX_B: begin
                bus2_sel = B2_ALU;
                case (dec_class)
                    C_ADDIU: begin
                        bus1_sel   = B1_SEXT;
                        alu_op     = ALU_ADD;
                        load_reg   = NUM_REGS'(1) << dec_rx;
                        Load_alu_Z = 1'b1;
                        state_d    = end_state;
                    end
                    C_LI: begin
                        bus1_sel = B1_ZEXT;
                        alu_op   = ALU_PASS;
                        load_reg = NUM_REGS'(1) << dec_rx;
                        state_d  = end_state;
                    end
                    C_ADDU, C_SUBU: begin
                        bus1_sel = B1_REGS;
                        rf_sel   = dec_ry;
                        alu_op   = (dec_class == C_SUBU) ? ALU_SUB : ALU_ADD;
                        load_reg = NUM_REGS'(1) << dec_rz;
                        state_d  = end_state;
                    end
                    C_LW, C_SW: begin
                        bus1_sel   = B1_ZEXT;
                        alu_op     = ALU_ADD;
                        Load_add_r = 1'b1;
                        state_d    = (dec_class == C_LW) ? S_MEM_R : S_EX_C;
                    end
                    default: begin
                        bus1_sel = B1_SEXT;
                        alu_op   = ALU_ADD;
                        Load_pc  = 1'b1;
                        state_d  = end_state;
                    end
                endcase
            end
            S_EX_C: begin
                rf_sel      = dec_ry;
                bus2_sel    = B2_RY;
                Load_data_r = 1'b1;
                state_d     = S_MEM_W;
            end
            S_MEM_R: begin
                mem_rd = 1'b1;
                if (mem_done) begin
                    bus2_sel = B2_MEM;
                    load_reg = NUM_REGS'(1) << dec_ry;
                    state_d  = end_state;
                end
            end
            S_MEM_W: begin
                mem_wr = 1'b1;
                if (mem_done) state_d = end_state;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_m1_control_unit.sv
// Bench for m1_control_unit: directed and random instruction streams against a micro-op list model.
// Latency: checks every cycle at the falling edge.
// Backpressure: bench drives mem_ready (waits only matter when M1_CTRL_WAIT_EN is defined).
module tb_m1_control_unit;

`ifdef M1_CTRL_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, run, Z_flag, mem_ready;
    logic [15:0] instruction;
    logic        Load_ir, Load_pc, Inc_pc, Load_add_r, Load_data_r;
    logic        Load_Reg_X, Load_Reg_Y, Load_Reg_Z, Load_Reg_SP, Load_Reg_T, Load_Reg_IH;
    logic        Load_Reg_alu_Y, Load_alu_Z;
    logic [2:0]  bus1_sel, bus2_sel, rf_sel;
    logic [3:0]  alu_op;
    logic        mem_rd, mem_wr, halted, illegal_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m1_control_unit dut (
        .clk(clk), .rst(rst), .run(run), .instruction(instruction),
        .Z_flag(Z_flag), .mem_ready(mem_ready),
        .Load_ir(Load_ir), .Load_pc(Load_pc), .Inc_pc(Inc_pc),
        .Load_add_r(Load_add_r), .Load_data_r(Load_data_r),
        .Load_Reg_X(Load_Reg_X), .Load_Reg_Y(Load_Reg_Y), .Load_Reg_Z(Load_Reg_Z),
        .Load_Reg_SP(Load_Reg_SP), .Load_Reg_T(Load_Reg_T), .Load_Reg_IH(Load_Reg_IH),
        .Load_Reg_alu_Y(Load_Reg_alu_Y), .Load_alu_Z(Load_alu_Z),
        .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .rf_sel(rf_sel), .alu_op(alu_op),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic       load_ir, load_pc, inc_pc, load_add_r, load_data_r;
        logic [5:0] load_reg;
        logic       load_alu_y, load_alu_z;
        logic [2:0] bus1, bus2, rf;
        logic [3:0] alu;
        logic       mem_rd, mem_wr, halted, illegal;
    } ov_t;

    typedef struct packed {
        ov_t  done_v;
        ov_t  wait_v;
        logic mem;
    } step_t;

    step_t steps[$];

    function automatic ov_t nil();
        ov_t v;
        v = '0;
        return v;
    endfunction

    function automatic ov_t sample();
        ov_t v;
        v.load_ir     = Load_ir;
        v.load_pc     = Load_pc;
        v.inc_pc      = Inc_pc;
        v.load_add_r  = Load_add_r;
        v.load_data_r = Load_data_r;
        v.load_reg    = {Load_Reg_IH, Load_Reg_T, Load_Reg_SP, Load_Reg_Z, Load_Reg_Y, Load_Reg_X};
        v.load_alu_y  = Load_Reg_alu_Y;
        v.load_alu_z  = Load_alu_Z;
        v.bus1        = bus1_sel;
        v.bus2        = bus2_sel;
        v.rf          = rf_sel;
        v.alu         = alu_op;
        v.mem_rd      = mem_rd;
        v.mem_wr      = mem_wr;
        v.halted      = halted;
        v.illegal     = illegal_op;
        return v;
    endfunction

    task automatic check(input string tag, input ov_t exp);
        ov_t obs;
        obs = sample();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input ov_t d, input ov_t w, input logic m);
        step_t s;
        s.done_v = d;
        s.wait_v = w;
        s.mem    = m;
        steps.push_back(s);
    endtask

    // alu_Y <= register r (via the write bus)
    task automatic push_ld_y(input logic [2:0] r);
        ov_t v;
        v = nil(); v.rf = r; v.bus2 = 3'd3; v.load_alu_y = 1'b1;
        push(v, nil(), 1'b0);
    endtask

    // alu_Y <= PC, then PC <= alu_Y + sext(imm)
    task automatic push_branch();
        ov_t v;
        v = nil(); v.bus2 = 3'd0; v.load_alu_y = 1'b1;
        push(v, nil(), 1'b0);
        v = nil(); v.bus1 = 3'd1; v.alu = 4'd1; v.bus2 = 3'd1; v.load_pc = 1'b1;
        push(v, nil(), 1'b0);
    endtask

    // Address <= alu_Y + zext(imm5)
    task automatic push_addr();
        ov_t v;
        v = nil(); v.bus1 = 3'd2; v.alu = 4'd1; v.bus2 = 3'd1; v.load_add_r = 1'b1;
        push(v, nil(), 1'b0);
    endtask

    // Reference: the per-cycle micro-op list of one instruction
    task automatic build(input logic [15:0] ins, input logic zf, output logic halts, output logic illeg);
        logic [4:0] op, fn;
        logic [2:0] rx, ry, rz;
        ov_t v, w;
        op = ins[15:11]; rx = ins[10:8]; ry = ins[7:5]; rz = ins[4:2]; fn = ins[4:0];
        halts = 1'b0;
        illeg = 1'b0;
        steps.delete();
        v = nil(); v.load_add_r = 1'b1;
        push(v, nil(), 1'b0);
        w = nil(); w.mem_rd = 1'b1;
        v = w; v.bus2 = 3'd2; v.load_ir = 1'b1; v.inc_pc = 1'b1;
        push(v, w, 1'b1);
        push(nil(), nil(), 1'b0);
        case (op)
            5'b01001: if (rx > 5) illeg = 1'b1; else begin
                push_ld_y(rx);
                v = nil(); v.bus1 = 3'd1; v.alu = 4'd1; v.bus2 = 3'd1;
                v.load_reg[rx] = 1'b1; v.load_alu_z = 1'b1;
                push(v, nil(), 1'b0);
            end
            5'b01101: if (rx > 5) illeg = 1'b1; else begin
                v = nil(); v.bus1 = 3'd2; v.alu = 4'd0; v.bus2 = 3'd1; v.load_reg[rx] = 1'b1;
                push(v, nil(), 1'b0);
            end
            5'b11100: if (fn[0] != 1'b1 || rx > 5 || ry > 5 || rz > 5) illeg = 1'b1; else begin
                push_ld_y(rx);
                v = nil(); v.rf = ry; v.alu = fn[1] ? 4'd2 : 4'd1; v.bus2 = 3'd1;
                v.load_reg[rz] = 1'b1;
                push(v, nil(), 1'b0);
            end
            5'b10011: if (rx > 5 || ry > 5) illeg = 1'b1; else begin
                push_ld_y(rx);
                push_addr();
                w = nil(); w.mem_rd = 1'b1;
                v = w; v.bus2 = 3'd2; v.load_reg[ry] = 1'b1;
                push(v, w, 1'b1);
            end
            5'b11011: if (rx > 5 || ry > 5) illeg = 1'b1; else begin
                push_ld_y(rx);
                push_addr();
                v = nil(); v.rf = ry; v.bus2 = 3'd4; v.load_data_r = 1'b1;
                push(v, nil(), 1'b0);
                w = nil(); w.mem_wr = 1'b1;
                push(w, w, 1'b1);
            end
            5'b00010: push_branch();
            5'b00100, 5'b00101: if (rx > 5) illeg = 1'b1; else begin
                v = nil(); v.rf = rx; v.load_alu_z = 1'b1;
                push(v, nil(), 1'b0);
                push(nil(), nil(), 1'b0);
                if ((op == 5'b00100) ? zf : !zf) push_branch();
            end
            5'b11101: if (fn == 5'b00101) halts = 1'b1; else illeg = 1'b1;
            default: illeg = 1'b1;
        endcase
        if (illeg) halts = 1'b1;
    endtask

    task automatic start_batch(input string name);
        @(posedge clk); #1;
        run = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check(name, nil());
    endtask

    task automatic exec_instr(input string name, input logic [15:0] ins, input logic zf,
                              input logic last, input int forced_wait, input logic rst_in_memw,
                              output logic halts);
        logic il, eff, mem_start;
        int   waits_left, idx;
        ov_t  exp;
        build(ins, zf, halts, il);
        idx = 0;
        waits_left = 0;
        mem_start = 1'b1;
        while (steps.size() > 0) begin
            @(posedge clk); #1;
            if (idx == 0) begin
                instruction = ins;
                Z_flag = zf;
                if (last) run = 1'b0;
            end
            eff = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
            if (steps[0].mem) begin
                if (mem_start) begin
                    waits_left = (forced_wait >= 0) ? forced_wait : $urandom_range(0, 3);
                    mem_start = 1'b0;
                end
                if (WAIT_MODE) begin
                    eff = (waits_left == 0);
                    mem_ready = eff;
                end
            end
            exp = eff ? steps[0].done_v : steps[0].wait_v;
            if (rst_in_memw && steps[0].mem && steps[0].done_v.mem_wr) begin
                if (WAIT_MODE) begin
                    mem_ready = 1'b0;
                    exp = steps[0].wait_v;
                end
                rst = 1'b1;
                run = 1'b0;
                @(negedge clk);
                check({name, " memw before rst"}, exp);
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check({name, " after rst"}, nil());
                steps.delete();
                halts = 1'b0;
                return;
            end
            @(negedge clk);
            check($sformatf("%s step%0d", name, idx), exp);
            idx++;
            if (eff) begin
                void'(steps.pop_front());
                mem_start = 1'b1;
            end else begin
                waits_left--;
            end
        end
        if (last && !halts) begin
            repeat (2) begin
                @(posedge clk); #1;
                mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check({name, " idle"}, nil());
            end
        end
    endtask

    task automatic check_halt(input string name, input logic il);
        ov_t v;
        v = nil(); v.halted = 1'b1; v.illegal = il;
        repeat (3) begin
            @(posedge clk); #1;
            run = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            Z_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
            check(name, v);
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1;
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(name, nil());
    endtask

    function automatic logic [15:0] rand_instr();
        logic [2:0]  rx, ry, rz;
        logic [7:0]  i8;
        logic [4:0]  i5;
        logic [10:0] i11;
        rx  = 3'($urandom_range(0, 5));
        ry  = 3'($urandom_range(0, 5));
        rz  = 3'($urandom_range(0, 5));
        i8  = 8'($urandom);
        i5  = 5'($urandom);
        i11 = 11'($urandom);
        case ($urandom_range(0, 8))
            0: return {5'b01001, rx, i8};
            1: return {5'b01101, rx, i8};
            2: return {5'b11100, rx, ry, rz, 2'b01};
            3: return {5'b11100, rx, ry, rz, 2'b11};
            4: return {5'b10011, rx, ry, i5};
            5: return {5'b11011, rx, ry, i5};
            6: return {5'b00010, i11};
            7: return {5'b00100, rx, i8};
            default: return {5'b00101, rx, i8};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        rst = 1'b1; run = 1'b0; Z_flag = 1'b0; mem_ready = 1'b0; instruction = '0;
        do_reset("reset");
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle hold", nil());

        start_batch("start directed");
        exec_instr("addiu", 16'h4903, 1'b0, 1'b0, -1, 1'b0, h);
        exec_instr("lw_wait", 16'h9820, 1'b0, 1'b0, 3, 1'b0, h);
        exec_instr("beqz_taken", 16'h2005, 1'b1, 1'b0, -1, 1'b0, h);
        exec_instr("beqz_not", 16'h2005, 1'b0, 1'b0, -1, 1'b0, h);
        exec_instr("bnez_taken", 16'h2805, 1'b0, 1'b0, -1, 1'b0, h);
        exec_instr("li", 16'h6D7F, 1'b0, 1'b0, -1, 1'b0, h);
        exec_instr("subu", 16'hE0B7, 1'b0, 1'b0, -1, 1'b0, h);
        exec_instr("sw_last", 16'hD941, 1'b0, 1'b1, -1, 1'b0, h);

        for (int b = 0; b < 8; b++) begin
            int n;
            n = $urandom_range(3, 8);
            start_batch($sformatf("start rnd%0d", b));
            for (int i = 0; i < n; i++) begin
                exec_instr($sformatf("rnd%0d_%0d", b, i), rand_instr(),
                           1'($urandom_range(0, 1)), (i == n - 1), -1, 1'b0, h);
            end
        end

        start_batch("start illegal");
        exec_instr("unknown_op", 16'h0700, 1'b0, 1'b1, -1, 1'b0, h);
        check_halt("illegal halt", 1'b1);
        do_reset("reset after illegal");

        start_batch("start reg6");
        exec_instr("addiu_reg6", 16'h4E00, 1'b0, 1'b1, -1, 1'b0, h);
        check_halt("reg6 halt", 1'b1);
        do_reset("reset after reg6");

        start_batch("start rrr_bad");
        exec_instr("rrr_bad_funct", 16'hE100, 1'b0, 1'b1, -1, 1'b0, h);
        check_halt("rrr halt", 1'b1);
        do_reset("reset after rrr");

        start_batch("start break");
        exec_instr("break", 16'hE805, 1'b0, 1'b1, -1, 1'b0, h);
        check_halt("break halt", 1'b0);
        do_reset("reset after break");

        start_batch("start sw rst");
        exec_instr("sw_rst", 16'hD941, 1'b0, 1'b0, 2, 1'b1, h);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle after rst", nil());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
